// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline register built as a two-entry skid buffer: registered ready
// upstream, valid/payload straight from the main entry downstream.
module id_ex_skid_stage #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] rs_data_i,
   input  logic [DATA_W-1:0] rt_data_i,
   input  logic [DATA_W-1:0] imm_i,
   input  logic [4:0]        rd_addr_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic              flush_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] rs_data_o,
   output logic [DATA_W-1:0] rt_data_o,
   output logic [DATA_W-1:0] imm_o,
   output logic [4:0]        rd_addr_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [15:0]       stall_cnt_o
);

   typedef struct packed {
      logic [DATA_W-1:0] rs;
      logic [DATA_W-1:0] rt;
      logic [DATA_W-1:0] imm;
      logic [4:0]        rd;
      logic [CTRL_W-1:0] ctrl;
   } beat_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   beat_t       main_q, skid_q, in_beat;
   logic        in_ready_q;
   logic [15:0] stall_q;
   logic        in_xfer, out_xfer;
   logic        load_main, load_skid, skid_to_main;

   assign in_beat  = {rs_data_i, rt_data_i, imm_i, rd_addr_i, ctrl_i};
   assign in_xfer  = in_valid_i && in_ready_q;
   assign out_xfer = (state_q != S_EMPTY) && out_ready_i;

   always_comb begin
      state_d      = state_q;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      unique case (state_q)
         S_EMPTY: begin
            if (in_xfer) begin
               load_main = 1'b1;
               state_d   = S_ONE;
            end
         end
         S_ONE: begin
            if (in_xfer && out_xfer) begin
               load_main = 1'b1;
            end else if (in_xfer) begin
               load_skid = 1'b1;
               state_d   = S_FULL;
            end else if (out_xfer) begin
               state_d = S_EMPTY;
            end
         end
         S_FULL: begin
            if (out_xfer) begin
               skid_to_main = 1'b1;
               state_d      = S_ONE;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      // Flush wins over everything; payload is left stale, out_valid hides it.
      if (flush_i) begin
         state_d      = S_EMPTY;
         load_main    = 1'b0;
         load_skid    = 1'b0;
         skid_to_main = 1'b0;
      end
   end

   // Ready is computed from the next state so it never depends on out_ready_i
   // combinationally at the output.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != S_FULL);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main)         main_q <= in_beat;
         else if (skid_to_main) main_q <= skid_q;
         if (load_skid)         skid_q <= in_beat;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_q <= '0;
      end else if (in_valid_i && !in_ready_q && !flush_i && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = (state_q != S_EMPTY);
   assign rs_data_o   = main_q.rs;
   assign rt_data_o   = main_q.rt;
   assign imm_o       = main_q.imm;
   assign rd_addr_o   = main_q.rd;
   assign ctrl_o      = main_q.ctrl;
   assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Self-checking bench for id_ex_skid_stage: a queue scoreboard tracks accepted
// beats, and each scenario task compares DUT outputs against it inline.
module tb_id_ex_skid_stage;
   localparam int DW = 32;
   localparam int CW = 10;
   localparam int PW = 3*DW + 5 + CW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] rs_d = '0, rt_d = '0, imm_d = '0;
   logic [4:0]    rd_d = '0;
   logic [CW-1:0] ctrl_d = '0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] rs_o, rt_o, imm_o;
   logic [4:0]    rd_o;
   logic [CW-1:0] ctrl_o;
   logic [15:0]   stall_cnt;

   logic [PW-1:0] mq[$];
   logic [15:0]   exp_stall = '0;
   int            outs = 0;
   int            total = 0;
   int            bad = 0;
   logic [PW-1:0] dut_beat;

   assign dut_beat = {rs_o, rt_o, imm_o, rd_o, ctrl_o};

   always #5 clk = ~clk;

   id_ex_skid_stage #(.DATA_W(DW), .CTRL_W(CW)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .rs_data_i(rs_d), .rt_data_i(rt_d), .imm_i(imm_d),
      .rd_addr_i(rd_d), .ctrl_i(ctrl_d), .flush_i(flush),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .rs_data_o(rs_o), .rt_data_o(rt_o), .imm_o(imm_o),
      .rd_addr_o(rd_o), .ctrl_o(ctrl_o), .stall_cnt_o(stall_cnt)
   );

   function automatic logic [PW-1:0] cur_beat();
      return {rs_d, rt_d, imm_d, rd_d, ctrl_d};
   endfunction

   task automatic set_beat(input logic [PW-1:0] b);
      {rs_d, rt_d, imm_d, rd_d, ctrl_d} = b;
   endtask

   function automatic logic [PW-1:0] rand_beat();
      logic [4:0]    r;
      logic [CW-1:0] c;
      r = 5'($urandom);
      c = CW'($urandom);
      return {32'($urandom), 32'($urandom), 32'($urandom), r, c};
   endfunction

   // Advance one clock, updating the scoreboard from the current inputs.
   task automatic tick();
      logic in_x, out_x;
      in_x  = in_valid && (mq.size() < 2);
      out_x = (mq.size() > 0) && out_ready;
      if (in_valid && mq.size() == 2 && !flush && exp_stall != 16'hFFFF)
         exp_stall = exp_stall + 16'd1;
      @(posedge clk);
      if (flush) mq.delete();
      else begin
         if (out_x) begin void'(mq.pop_front()); outs++; end
         if (in_x) mq.push_back(cur_beat());
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      in_valid = 0; flush = 0; out_ready = 0;
      rst = 1;
      @(negedge clk); @(negedge clk);
      rst = 0;
      mq.delete();
      exp_stall = '0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      total++; if (dut_beat !== '0) begin bad++; $display("FAIL reset_payload: got %h want 0", dut_beat); end
      total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall: got %h want 0", stall_cnt); end
   endtask

   task automatic test_single();
      do_reset();
      out_ready = 1;
      set_beat(rand_beat());
      imm_d = 32'hFFFF_8000; rd_d = 5'd9;
      in_valid = 1;
      tick();
      in_valid = 0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
      total++; if (imm_o !== 32'hFFFF_8000) begin bad++; $display("FAIL single_imm: got %h want ffff8000", imm_o); end
      total++; if (rd_o !== 5'd9) begin bad++; $display("FAIL single_rd: got %0d want 9", rd_o); end
      total++; if (mq.size() != 1 || dut_beat !== mq[0]) begin bad++; $display("FAIL single_payload: got %h", dut_beat); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [PW-1:0] beats [4];
      int in_idx, out_idx, cyc;
      do_reset();
      for (int i = 0; i < 4; i++) beats[i] = rand_beat();
      in_idx = 0; out_idx = 0;
      out_ready = 0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1; set_beat(beats[in_idx]);
         if (mq.size() < 2) in_idx++;
         tick();
      end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL bp_stall2: got %0d want 2", stall_cnt); end
      total++; if (dut_beat !== beats[0]) begin bad++; $display("FAIL bp_head_stable: got %h want %h", dut_beat, beats[0]); end
      out_ready = 1;
      cyc = 0;
      while (out_idx < 4 && cyc < 50) begin
         in_valid = (in_idx < 4);
         if (in_idx < 4) set_beat(beats[in_idx]);
         total++; if (in_ready !== (mq.size() < 2)) begin bad++; $display("FAIL bp_ready: got %b want %b", in_ready, mq.size() < 2); end
         if (out_valid) begin
            total++; if (dut_beat !== beats[out_idx]) begin bad++; $display("FAIL bp_order%0d: got %h want %h", out_idx, dut_beat, beats[out_idx]); end
            out_idx++;
         end
         if (in_valid && mq.size() < 2) in_idx++;
         tick(); cyc++;
      end
      in_valid = 0;
      total++; if (out_idx != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", out_idx); end
      total++; if (stall_cnt !== exp_stall) begin bad++; $display("FAIL bp_stall: got %0d want %0d", stall_cnt, exp_stall); end
   endtask

   task automatic test_back_to_back();
      int start;
      do_reset();
      out_ready = 1;
      start = outs;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1; set_beat(rand_beat());
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
         if (i > 0) begin
            total++; if (out_valid !== 1'b1 || dut_beat !== mq[0]) begin bad++; $display("FAIL b2b_out%0d: got %b/%h want 1/%h", i, out_valid, dut_beat, mq[0]); end
         end
         tick();
      end
      in_valid = 0;
      tick();
      total++; if (outs - start != 100) begin bad++; $display("FAIL b2b_count: got %0d want 100", outs - start); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
      total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL b2b_stall: got %0d want 0", stall_cnt); end
   endtask

   task automatic test_flush();
      do_reset();
      out_ready = 0;
      in_valid = 1;
      set_beat(rand_beat()); tick();
      set_beat(rand_beat()); tick();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_full: got %b want 0", in_ready); end
      set_beat(rand_beat()); flush = 1;
      tick();
      flush = 0; in_valid = 0; out_ready = 1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready: got %b want 1", in_ready); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost%0d: got %b want 0", i, out_valid); end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      out_ready = 0; in_valid = 1;
      set_beat(rand_beat()); tick();
      set_beat(rand_beat()); tick();
      tick();
      total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL ar_pre_stall: got %0d want 1", stall_cnt); end
      #2 rst = 1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b want 0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ar_ready: got %b want 1", in_ready); end
      total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL ar_stall: got %0d want 0", stall_cnt); end
      total++; if (dut_beat !== '0) begin bad++; $display("FAIL ar_payload: got %h want 0", dut_beat); end
      @(negedge clk);
      rst = 0; mq.delete(); exp_stall = '0;
      out_ready = 1; set_beat(rand_beat());
      tick();
      in_valid = 0;
      total++; if (out_valid !== 1'b1 || dut_beat !== mq[0]) begin bad++; $display("FAIL ar_first: got %b/%h want 1/%h", out_valid, dut_beat, mq[0]); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_dup: got %b want 0", out_valid); end
   endtask

   task automatic test_saturate();
      logic [PW-1:0] head;
      do_reset();
      out_ready = 0; in_valid = 1;
      set_beat(rand_beat()); tick();
      head = mq[0];
      set_beat(rand_beat()); tick();
      set_beat(rand_beat());
      for (int i = 0; i < 65534; i++) tick();
      total++; if (stall_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_fffe: got %h want fffe", stall_cnt); end
      tick();
      total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_ffff: got %h want ffff", stall_cnt); end
      for (int i = 0; i < 70000 - 65535; i++) tick();
      total++; if (stall_cnt !== 16'hFFFF || exp_stall !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h want ffff", stall_cnt); end
      total++; if (dut_beat !== head) begin bad++; $display("FAIL sat_stable: got %h want %h", dut_beat, head); end
      in_valid = 0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
